stcam_lookup_ctrl: RTL and testbench
====================================

Name: stcam_lookup_ctrl

Overview:
Initiator side of the STCAM row array. Accepts write, invalidate and search requests on a valid/ready interface, drives the array's per-row write enables, search bits and don't-care bits, and samples the returned per-row match lines. It priority-encodes the matches into a hit/index response, with a registered per-entry valid vector so unwritten rows never hit.

Parameters:
WIDTH, 8, key bits per entry (cells per row)
ENTRIES, 16, number of CAM rows
IDX_W, $clog2(ENTRIES), entry index width

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets)
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  2  00 search, 01 write, 10 invalidate, 11 reserved (accepted, no effect)
req_key  in  WIDTH  search key / data to write
req_mask  in  WIDTH  don't-care bits for write (1 = X)
req_index  in  IDX_W  target row for write/invalidate
arr_we  out  ENTRIES  one-hot row write enable
arr_search_bits  out  WIDTH  key or write data to every row
arr_dont_care_bits  out  WIDTH  write mask during WRITE, 0 otherwise
arr_match  in  ENTRIES  per-row match line (row chain output)
rsp_valid  out  1  search result present
rsp_ready  in  1  consumer accepts result
rsp_hit  out  1  at least one valid row matched
rsp_index  out  IDX_W  lowest matching row index (0 if no hit)
rsp_multi  out  1  more than one valid row matched

Behaviour:
- Reset (rst==0 at edge): state IDLE, valid_q=0, req_ready=0 during the reset cycle and 1 after; rsp_valid/hit/multi=0, rsp_index=0, arr_we=0, arr_search_bits=0, arr_dont_care_bits=0. Reset overrides any state, including mid-search and mid-write; an in-flight search is dropped and no response is produced.
- States: IDLE, WRITE, DRIVE, RESP. req_ready=1 only in IDLE. A request is accepted on an edge with req_valid&&req_ready.
- IDLE + search accepted: latch key -> DRIVE.
- DRIVE (1 cycle): arr_search_bits=key_q. At the end-of-cycle edge, match_q <= arr_match & valid_q -> RESP. Result is visible 2 edges after acceptance.
- RESP: rsp_valid=1. rsp_hit=|match_q. rsp_index=lowest set bit of match_q. rsp_multi=1 when popcount>1. Outputs hold stable until rsp_valid&&rsp_ready, then -> IDLE. No new request is accepted while in RESP.
- IDLE + write accepted, index<ENTRIES: -> WRITE. For 1 cycle: arr_we[index]=1, arr_search_bits=key_q, arr_dont_care_bits=mask_q. At the end-of-cycle edge: valid_q[index]<=1 -> IDLE. No response.
- Write with index>=ENTRIES: accepted, no array activity, stays IDLE.
- Invalidate accepted: valid_q[index]<=0 on the acceptance edge (ignored if out of range), stays IDLE, no response.
- Rewriting a valid row overwrites it; valid stays 1.
- arr_we is all-zero outside WRITE. Search-time arr_dont_care_bits=0.
- Back-to-back: IDLE re-accepts on the cycle after WRITE or after the RESP handshake. Minimum search throughput is one per 3 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from req_* or arr_match to any output.

Decomposition:
- Package stcam_pkg: op encodings (OP_SEARCH, OP_WRITE, OP_INVAL), state enum, default WIDTH/ENTRIES.
- Sub-module stcam_prio_enc, purely combinational: ENTRIES-bit vector -> hit, lowest index, multi. It is instantiated on match_q.

Test Plan:
- Reset then search key 8'hA5 with no writes -> rsp_valid 2 edges after accept, hit=0, index=0, multi=0. arr_we stays 0 throughout.
- Write row 3 key 8'hA5 mask 0 -> arr_we=16'h0008 for exactly one cycle with search_bits=A5. Search A5 -> hit=1, index=3, multi=0. Search A4 -> hit=0.
- Write row 7 key 8'hA0 mask 8'h0F, plus the row-3 entry above. Search A5 -> hit=1, index=3, multi=1. Invalidate row 3, search A5 -> index=7, multi=0.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/hit/index stable and req_ready=0 throughout. The response is consumed on the first rsp_ready=1 edge, and IDLE follows.
- Write with req_index=16 (ENTRIES=16) -> arr_we never asserted. Subsequent searches unaffected.
- Assert rst=0 during DRIVE after a valid write -> no rsp_valid ever for that search, valid_q cleared. A search for the previously written key then returns hit=0.

Source files
------------

// File: rtl/stcam_pkg.sv
// ---------------------------------------------------------------------------
// stcam_pkg
// Shared definitions for the STCAM lookup controller:
//   - default geometry (key width, number of rows)
//   - request opcode encoding seen on req_op
//   - controller state encoding
// ---------------------------------------------------------------------------
package stcam_pkg;

   localparam int WIDTH_DEF   = 8;
   localparam int ENTRIES_DEF = 16;

   typedef enum logic [1:0] {
      OP_SEARCH = 2'b00,
      OP_WRITE  = 2'b01,
      OP_INVAL  = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_DRIVE,
      ST_RESP
   } state_e;

endpackage

// File: rtl/stcam_prio_enc.sv
// ---------------------------------------------------------------------------
// stcam_prio_enc
// Purely combinational priority encoder over the per-row match vector.
// Ports:
//   vec    in  ENTRIES  qualified match lines (bit i = row i matched)
//   hit    out 1        at least one bit set
//   index  out IDX_W    index of the lowest set bit (0 when no bit is set)
//   multi  out 1        more than one bit set
// ---------------------------------------------------------------------------
module stcam_prio_enc
   import stcam_pkg::*;
#(
   parameter int ENTRIES = ENTRIES_DEF,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic [ENTRIES-1:0] vec,
   output logic               hit,
   output logic [IDX_W-1:0]   index,
   output logic               multi
);

   // Scanning from the top row down leaves the lowest match in index; any
   // match found while hit is already set means a second row matched.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path through
      // this block leaves a variable unassigned and no latch is inferred.
      hit   = 1'b0;
      index = '0;
      multi = 1'b0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (vec[i]) begin
            multi = multi | hit;
            hit   = 1'b1;
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/stcam_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// stcam_lookup_ctrl
// Initiator side of the STCAM row array. Accepts search / write / invalidate
// requests, drives the row array, and returns a priority-encoded search
// result. A per-row valid vector masks match lines of rows never written or
// since invalidated.
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_op               00 search, 01 write, 10 invalidate, 11 no effect
//   req_key, req_mask    search key / write data, write don't-care bits
//   req_index            target row for write / invalidate
//   arr_we               one-hot row write enable (WRITE state only)
//   arr_search_bits      key or write data broadcast to every row
//   arr_dont_care_bits   write mask during WRITE, 0 otherwise
//   arr_match            per-row match lines from the array
//   rsp_valid/rsp_ready  response handshake
//   rsp_hit/index/multi  search result (lowest matching valid row)
// ---------------------------------------------------------------------------
module stcam_lookup_ctrl
   import stcam_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int ENTRIES = ENTRIES_DEF,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [WIDTH-1:0]   req_key,
   input  logic [WIDTH-1:0]   req_mask,
   input  logic [IDX_W-1:0]   req_index,
   output logic [ENTRIES-1:0] arr_we,
   output logic [WIDTH-1:0]   arr_search_bits,
   output logic [WIDTH-1:0]   arr_dont_care_bits,
   input  logic [ENTRIES-1:0] arr_match,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_hit,
   output logic [IDX_W-1:0]   rsp_index,
   output logic               rsp_multi
);

   // Compared one bit wider so that ENTRIES itself is representable even when
   // IDX_W is exactly $clog2(ENTRIES).
   function automatic logic in_range(input logic [IDX_W-1:0] idx);
      return {1'b0, idx} < (IDX_W + 1)'(ENTRIES);
   endfunction

   function automatic logic [ENTRIES-1:0] row_sel(input logic [IDX_W-1:0] idx);
      return in_range(idx) ? (ENTRIES'(1) << idx) : '0;
   endfunction

   state_e             state_q,  state_d;
   logic               ready_q,  ready_d;
   logic [WIDTH-1:0]   key_q,    key_d;
   logic [WIDTH-1:0]   mask_q,   mask_d;
   logic [IDX_W-1:0]   idx_q,    idx_d;
   logic [ENTRIES-1:0] valid_q,  valid_d;
   logic [ENTRIES-1:0] match_q,  match_d;

   logic               accept;
   logic               enc_hit;
   logic [IDX_W-1:0]   enc_index;
   logic               enc_multi;

   assign accept = req_valid && ready_q;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      mask_d  = mask_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      match_d = match_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               key_d  = req_key;
               mask_d = req_mask;
               idx_d  = req_index;
               case (op_e'(req_op))
                  OP_SEARCH: state_d = ST_DRIVE;
                  // Out-of-range writes are consumed without touching the array.
                  OP_WRITE:  if (in_range(req_index)) state_d = ST_WRITE;
                  OP_INVAL:  valid_d = valid_q & ~row_sel(req_index);
                  default:   ;
               endcase
            end
         end
         ST_WRITE: begin
            valid_d = valid_q | row_sel(idx_q);
            state_d = ST_IDLE;
         end
         ST_DRIVE: begin
            // Match lines of unwritten / invalidated rows are discarded here.
            match_d = arr_match & valid_q;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered ready: low while reset is applied, and never a function of
      // the current cycle's request inputs.
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         key_q   <= '0;
         mask_q  <= '0;
         idx_q   <= '0;
         // NOTE: valid_q must be cleared by reset -- it is the only thing that
         // stops stale array contents from hitting after reset.
         valid_q <= '0;
         match_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge
         // values computed by the always_comb block.
         state_q <= state_d;
         ready_q <= ready_d;
         key_q   <= key_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         match_q <= match_d;
      end
   end

   stcam_prio_enc #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_prio_enc (
      .vec   (match_q),
      .hit   (enc_hit),
      .index (enc_index),
      .multi (enc_multi)
   );

   // All outputs decode registered state only.
   assign req_ready          = ready_q;
   assign arr_we             = (state_q == ST_WRITE) ? row_sel(idx_q) : '0;
   assign arr_search_bits    = (state_q == ST_WRITE || state_q == ST_DRIVE) ? key_q : '0;
   assign arr_dont_care_bits = (state_q == ST_WRITE) ? mask_q : '0;
   assign rsp_valid          = (state_q == ST_RESP);
   assign rsp_hit            = rsp_valid & enc_hit;
   assign rsp_index          = rsp_valid ? enc_index : '0;
   assign rsp_multi          = rsp_valid & enc_multi;

endmodule

// File: tb/tb_stcam_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stcam_lookup_ctrl
// Bench for the STCAM lookup controller. A behavioural row array answers the
// controller's search bits; a reference CAM (rows of key/mask/valid) predicts
// each search result, which is queued and compared by a response monitor.
// The index port is one bit wider than $clog2(ENTRIES) so that row 16 can be
// requested as an out-of-range target.
// ---------------------------------------------------------------------------
module tb_stcam_lookup_ctrl;
   import stcam_pkg::*;

   localparam int WIDTH   = 8;
   localparam int ENTRIES = 16;
   localparam int IDX_W   = 5;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic [1:0]         req_op = 2'b00;
   logic [WIDTH-1:0]   req_key = '0;
   logic [WIDTH-1:0]   req_mask = '0;
   logic [IDX_W-1:0]   req_index = '0;
   logic [ENTRIES-1:0] arr_we;
   logic [WIDTH-1:0]   arr_search_bits;
   logic [WIDTH-1:0]   arr_dont_care_bits;
   logic [ENTRIES-1:0] arr_match;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic               rsp_hit;
   logic [IDX_W-1:0]   rsp_index;
   logic               rsp_multi;

   always #5 clk = ~clk;

   stcam_lookup_ctrl #(
      .WIDTH   (WIDTH),
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_op             (req_op),
      .req_key            (req_key),
      .req_mask           (req_mask),
      .req_index          (req_index),
      .arr_we             (arr_we),
      .arr_search_bits    (arr_search_bits),
      .arr_dont_care_bits (arr_dont_care_bits),
      .arr_match          (arr_match),
      .rsp_valid          (rsp_valid),
      .rsp_ready          (rsp_ready),
      .rsp_hit            (rsp_hit),
      .rsp_index          (rsp_index),
      .rsp_multi          (rsp_multi)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural row array (not reset, like real cells) -----
   logic [WIDTH-1:0]   mem_key [ENTRIES];
   logic [WIDTH-1:0]   mem_dc  [ENTRIES];
   logic [ENTRIES-1:0] mem_wr = '0;
   int                 we_cycles = 0;

   always @(posedge clk) begin
      for (int r = 0; r < ENTRIES; r++) begin
         if (arr_we[r]) begin
            mem_key[r] <= arr_search_bits;
            mem_dc[r]  <= arr_dont_care_bits;
            mem_wr[r]  <= 1'b1;
         end
      end
   end

   always_comb begin
      arr_match = '0;
      for (int r = 0; r < ENTRIES; r++)
         arr_match[r] = mem_wr[r] && (((arr_search_bits ^ mem_key[r]) & ~mem_dc[r]) == '0);
   end

   always @(negedge clk) begin
      if (arr_we != '0) begin
         we_cycles <= we_cycles + 1;
         check("arr_we_onehot", $countones(arr_we), 1);
      end
   end

   // ---------------- reference CAM and scoreboard ----------------------------
   typedef struct packed {
      logic             hit;
      logic             multi;
      logic [IDX_W-1:0] index;
   } rsp_t;

   logic [WIDTH-1:0] ref_key   [ENTRIES];
   logic [WIDTH-1:0] ref_mask  [ENTRIES];
   logic             ref_valid [ENTRIES];
   rsp_t             exp_q [$];

   function automatic rsp_t ref_search(input logic [WIDTH-1:0] key);
      rsp_t r   = '0;
      int   cnt = 0;
      for (int e = 0; e < ENTRIES; e++) begin
         if (ref_valid[e] && (((key ^ ref_key[e]) & ~ref_mask[e]) == '0)) begin
            if (cnt == 0) r.index = IDX_W'(e);
            cnt++;
         end
      end
      r.hit   = (cnt > 0);
      r.multi = (cnt > 1);
      return r;
   endfunction

   task automatic ref_clear();
      for (int e = 0; e < ENTRIES; e++) ref_valid[e] = 1'b0;
   endtask

   // Response monitor: a handshake happens at the next edge when both are high.
   always @(negedge clk) begin
      if (rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: got hit=%0b index=%0d, expected no response", rsp_hit, rsp_index);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp_hit",   rsp_hit,   e.hit);
            check("rsp_index", rsp_index, e.index);
            check("rsp_multi", rsp_multi, e.multi);
         end
      end
   end

   // ---------------- driver tasks (entered just after a rising edge) --------
   task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] key,
                       input logic [WIDTH-1:0] mask, input logic [IDX_W-1:0] idx);
      bit ok = 1'b0;
      req_op    = op;
      req_key   = key;
      req_mask  = mask;
      req_index = idx;
      req_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("req_accept", ok, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic do_write(input logic [IDX_W-1:0] idx, input logic [WIDTH-1:0] key,
                           input logic [WIDTH-1:0] mask);
      logic [ENTRIES-1:0] exp_we = '0;
      send(OP_WRITE, key, mask, idx);
      if (idx < ENTRIES) begin
         exp_we[idx[3:0]]      = 1'b1;
         ref_key[idx[3:0]]     = key;
         ref_mask[idx[3:0]]    = mask;
         ref_valid[idx[3:0]]   = 1'b1;
         check("wr_arr_we",    arr_we, exp_we);
         check("wr_search",    arr_search_bits, key);
         check("wr_dont_care", arr_dont_care_bits, mask);
         check("wr_ready_low", req_ready, 0);
         @(posedge clk);
         #1;
      end
      check("wr_we_clear",  arr_we, 0);
      check("wr_idle",      req_ready, 1);
   endtask

   task automatic do_other(input logic [1:0] op, input logic [IDX_W-1:0] idx);
      send(op, 8'hFF, 8'h00, idx);
      if (op == OP_INVAL && idx < ENTRIES) ref_valid[idx[3:0]] = 1'b0;
      check("op_idle",  req_ready, 1);
      check("op_no_we", arr_we, 0);
   endtask

   task automatic do_search(input logic [WIDTH-1:0] key, input int hold);
      rsp_t e;
      rsp_t snap;
      e = ref_search(key);
      send(OP_SEARCH, key, 8'h00, '0);
      exp_q.push_back(e);
      check("drv_no_rsp",    rsp_valid, 0);
      check("drv_ready_low", req_ready, 0);
      check("drv_search",    arr_search_bits, key);
      check("drv_dont_care", arr_dont_care_bits, 0);
      check("drv_no_we",     arr_we, 0);
      @(posedge clk);
      #1;
      check("rsp_latency", rsp_valid, 1);
      snap = '{hit: rsp_hit, multi: rsp_multi, index: rsp_index};
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check("hold_valid",  rsp_valid, 1);
         check("hold_ready",  req_ready, 0);
         check("hold_stable", {rsp_hit, rsp_multi, rsp_index}, snap);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("rsp_consumed", rsp_valid, 0);
      check("rsp_idle",     req_ready, 1);
   endtask

   // ---------------- main sequence ------------------------------------------
   initial begin
      int we0;
      ref_clear();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",     req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_hit",   rsp_hit, 0);
      check("rst_rsp_index", rsp_index, 0);
      check("rst_rsp_multi", rsp_multi, 0);
      check("rst_arr_we",    arr_we, 0);
      check("rst_search",    arr_search_bits, 0);
      check("rst_dont_care", arr_dont_care_bits, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", req_ready, 1);

      // Search on an empty CAM
      do_search(8'hA5, 0);
      check("no_we_yet", we_cycles, 0);

      // Single entry, exact match and miss
      do_write(5'd3, 8'hA5, 8'h00);
      do_search(8'hA5, 0);
      do_search(8'hA4, 0);

      // Overlapping entries, then invalidate the lower one
      do_write(5'd7, 8'hA0, 8'h0F);
      do_search(8'hA5, 0);
      do_other(OP_INVAL, 5'd3);
      do_search(8'hA5, 0);

      // Consumer back-pressure for 5 cycles
      do_search(8'hA5, 5);

      // Out-of-range write leaves the array alone
      we0 = we_cycles;
      do_write(5'd16, 8'h5A, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      check("oor_no_we", we_cycles, we0);
      do_search(8'h5A, 0);
      do_search(8'hA5, 0);

      // Reset while a search is in DRIVE: the search is dropped
      do_write(5'd5, 8'h3C, 8'h00);
      send(OP_SEARCH, 8'h3C, 8'h00, '0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_ready", req_ready, 0);
      check("mid_rst_rsp",   rsp_valid, 0);
      rst = 1'b1;
      ref_clear();
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         check("dropped_rsp", rsp_valid, 0);
      end
      check("mid_rst_idle", req_ready, 1);
      do_search(8'h3C, 0);

      // Randomized mix of operations
      for (int it = 0; it < 120; it++) begin
         logic [1:0]       op;
         logic [IDX_W-1:0] idx;
         logic [WIDTH-1:0] key;
         logic [WIDTH-1:0] mask;
         op   = 2'($urandom_range(0, 3));
         idx  = IDX_W'($urandom_range(0, 19));
         key  = 8'hA0 | WIDTH'($urandom_range(0, 7));
         mask = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : 8'h00;
         case (op)
            2'b00:   do_search(key, int'($urandom_range(0, 2)));
            2'b01:   do_write(idx, key, mask);
            default: do_other(op, idx);
         endcase
      end

      repeat (3) @(posedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog expired");
   end

endmodule
